fir_load_ctrl: RTL and testbench
================================

FIR_LOAD_CTRL -- requirements
Module: fir_load_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of sample and coefficient bytes.
REQ-002 Parameter NTAPS, default 3, number of FIR coefficients sequenced per load.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sample_in  input  DATA_W  signed upstream sample.
REQ-006 sample_valid  input  1  sample_in valid.
REQ-007 sample_ready  output  1  controller accepts a sample; a sample transfers when valid and ready are both high.
REQ-008 coeff_wr  input  1  host write strobe to the shadow coefficient bank.
REQ-009 coeff_addr  input  2  shadow bank index.
REQ-010 coeff_wdata  input  DATA_W  coefficient value.
REQ-011 load_req  input  1  single-cycle request to transfer the shadow bank into the FIR.
REQ-012 fir_x_n  output  DATA_W  registered data to FIR x_n.
REQ-013 fir_tvalid  output  1  registered, to FIR s_axis_fir_tvalid.
REQ-014 fir_set_coeffs  output  1  registered, to FIR s_set_coeffs.
REQ-015 busy  output  1  high in any state other than STREAM.
REQ-016 load_done  output  1  one-cycle pulse when a load sequence completes.
REQ-017 wr_err  output  1  one-cycle pulse when a host write is rejected.

Function
REQ-018 FSM states: STREAM, LOAD, FLUSH (FLUSH exists only with the macro; see REQ-030).
REQ-019 STREAM: sample_ready=1; on each edge fir_x_n<=sample_in, fir_tvalid<=sample_valid, fir_set_coeffs<=0; latency is 1 cycle.
REQ-020 STREAM->LOAD on the edge where load_req=1 or pending=1; a sample accepted in that same cycle is still forwarded.
REQ-021 LOAD: sample_ready=0; tap counter idx runs 0..NTAPS-1, one per cycle; the outputs are fir_x_n<=shadow[idx], fir_set_coeffs<=1, fir_tvalid<=0; coeff0 goes first.
REQ-022 When idx reaches NTAPS-1, the controller moves to STREAM (or FLUSH); load_done pulses on the cycle after the last coefficient is driven.
REQ-023 The shadow bank is snapshotted at LOAD entry; the sequenced values are the bank contents in the cycle load_req was taken.
REQ-024 When busy=1, host writes are ignored and wr_err pulses; when busy=0, a write to coeff_addr>=NTAPS is ignored and wr_err pulses.
REQ-025 load_req while busy sets a single pending flag; further requests while pending is set are merged; pending clears on LOAD entry.
REQ-026 A write and load_req in the same STREAM cycle: the write takes effect first, so the snapshot includes the new value.
REQ-027 Sample_valid while sample_ready=0 is not consumed; upstream holds the data.

Reset
REQ-028 Reset forces state=STREAM, idx=0, pending=0, shadow bank=0, fir_x_n=0, fir_tvalid=0, fir_set_coeffs=0, load_done=0, wr_err=0.
REQ-029 Reset mid-LOAD or mid-FLUSH aborts the sequence; fir_set_coeffs is low on the first cycle after reset and no load_done is issued.

Configuration
REQ-030 Macro FIR_CTRL_FLUSH_EN defined: after LOAD, the FSM enters FLUSH for NTAPS cycles with fir_x_n=0, fir_tvalid=1, fir_set_coeffs=0, sample_ready=0; load_done then pulses on exit from FLUSH.
REQ-031 Macro undefined: no FLUSH state; LOAD returns directly to STREAM.

Structure
REQ-032 Package fir_pkg holds DATA_W and NTAPS defaults, the FSM state typedef and the tap-index width constant.
REQ-033 Sub-module fir_coeff_bank implements the shadow registers, the address check and the snapshot; the FSM and output registers stay in fir_load_ctrl.

Verification
REQ-034 Pass-through: sample_in=0,1,0 with valid=1 -> fir_x_n=0,1,0 one cycle later, fir_tvalid=1, fir_set_coeffs=0.
REQ-035 Load: write 1,2,3 to addr 0,1,2, then load_req -> fir_x_n=1,2,3 on 3 consecutive cycles with fir_set_coeffs=1, fir_tvalid=0, then load_done=1 for one cycle.
REQ-036 Pending: load_req during LOAD -> a second identical 3-cycle sequence directly follows; two load_done pulses.
REQ-037 Write while busy: write 9 to addr 0 during LOAD -> wr_err pulse; a later load still sends 1,2,3; a write to addr 3 while idle -> wr_err pulse.
REQ-038 Reset after the second coefficient -> next cycle fir_set_coeffs=0, busy=0, no load_done; a new load sends 0,0,0.
REQ-039 With FIR_CTRL_FLUSH_EN: after 1,2,3 -> three zeros with fir_tvalid=1, sample_ready=0, then load_done.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR load-controller defaults, state encoding and tap-index width.
// FIR_CTRL_FLUSH_EN adds the FLUSH state.
package fir_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned NTAPS_DEF  = 3;
  localparam int unsigned TAP_W      = 2;

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_LOAD   = 2'd1
`ifdef FIR_CTRL_FLUSH_EN
    ,ST_FLUSH = 2'd2
`endif
  } fir_state_e;

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow coefficient registers with write qualification and a load-time snapshot.
// The snapshot takes a same-cycle host write into account.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NTAPS  = NTAPS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy_c,
  input  logic              wr,
  input  logic [TAP_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              snap,
  input  logic [TAP_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              wr_err_c
);

  logic [DATA_W-1:0] shadow_q [NTAPS];
  logic [DATA_W-1:0] snap_q   [NTAPS];
  logic              addr_ok_c;
  logic              wr_en_c;

  assign addr_ok_c = 32'(addr) < NTAPS;
  assign wr_en_c   = wr & ~busy_c & addr_ok_c;
  assign wr_err_c  = wr & (busy_c | ~addr_ok_c);

  // Shadow writes; the snapshot sees a write landing on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        shadow_q[i] <= '0;
        snap_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        if (wr_en_c && addr == TAP_W'(i)) shadow_q[i] <= wdata;
        if (snap) snap_q[i] <= (wr_en_c && addr == TAP_W'(i)) ? wdata : shadow_q[i];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < int'(NTAPS); i++) begin
      if (rd_idx == TAP_W'(i)) rd_data_c = snap_q[i];
    end
  end

endmodule

// File: rtl/fir_load_ctrl.sv
// Sequences the shadow coefficient bank into a FIR and streams samples otherwise.
// Optional post-load flush of zero samples enabled by FIR_CTRL_FLUSH_EN.
module fir_load_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NTAPS  = NTAPS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     coeff_wr,
  input  logic [1:0]               coeff_addr,
  input  logic [DATA_W-1:0]        coeff_wdata,
  input  logic                     load_req,
  output logic signed [DATA_W-1:0] fir_x_n,
  output logic                     fir_tvalid,
  output logic                     fir_set_coeffs,
  output logic                     busy,
  output logic                     load_done,
  output logic                     wr_err
);

  localparam logic [TAP_W-1:0] LAST_IDX = TAP_W'(NTAPS - 1);

  fir_state_e               state_q, state_d;
  logic [TAP_W-1:0]         idx_q, idx_d;
  logic                     pending_q, pending_d;
  logic                     fin_q, fin_d;
  logic signed [DATA_W-1:0] x_d;
  logic                     tvalid_d;
  logic                     setc_d;
  logic                     snap_c;
  logic                     busy_c;
  logic [DATA_W-1:0]        coeff_c;
  logic                     wr_err_c;

  assign busy_c = (state_q != ST_STREAM);

  fir_coeff_bank #(
    .DATA_W (DATA_W),
    .NTAPS  (NTAPS)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .busy_c    (busy_c),
    .wr        (coeff_wr),
    .addr      (TAP_W'(coeff_addr)),
    .wdata     (coeff_wdata),
    .snap      (snap_c),
    .rd_idx    (idx_q),
    .rd_data_c (coeff_c),
    .wr_err_c  (wr_err_c)
  );

  // State, counters and all output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_STREAM;
      idx_q          <= '0;
      pending_q      <= 1'b0;
      fin_q          <= 1'b0;
      fir_x_n        <= '0;
      fir_tvalid     <= 1'b0;
      fir_set_coeffs <= 1'b0;
      sample_ready   <= 1'b1;
      busy           <= 1'b0;
      load_done      <= 1'b0;
      wr_err         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pending_q      <= pending_d;
      fin_q          <= fin_d;
      fir_x_n        <= x_d;
      fir_tvalid     <= tvalid_d;
      fir_set_coeffs <= setc_d;
      sample_ready   <= (state_d == ST_STREAM);
      busy           <= (state_d != ST_STREAM);
      load_done      <= fin_q;
      wr_err         <= wr_err_c;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    fin_d     = 1'b0;
    snap_c    = 1'b0;
    x_d       = sample_in;
    tvalid_d  = sample_valid;
    setc_d    = 1'b0;

    if (busy_c && load_req) pending_d = 1'b1;

    unique case (state_q)
      ST_STREAM: begin
        if (load_req || pending_q) begin
          state_d   = ST_LOAD;
          idx_d     = '0;
          pending_d = 1'b0;
          snap_c    = 1'b1;
        end
      end
      ST_LOAD: begin
        x_d      = coeff_c;
        tvalid_d = 1'b0;
        setc_d   = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef FIR_CTRL_FLUSH_EN
          state_d = ST_FLUSH;
`else
          state_d = ST_STREAM;
          fin_d   = 1'b1;
`endif
        end else begin
          idx_d = idx_q + TAP_W'(1);
        end
      end
`ifdef FIR_CTRL_FLUSH_EN
      ST_FLUSH: begin
        x_d      = '0;
        tvalid_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_STREAM;
          fin_d   = 1'b1;
        end else begin
          idx_d = idx_q + TAP_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_STREAM;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_load_ctrl.sv
// Scoreboard bench for fir_load_ctrl: expected output events are queued as stimulus
// is driven and checked in order by a mid-cycle monitor.
module tb_fir_load_ctrl;

  localparam int K_DATA  = 0;
  localparam int K_COEFF = 1;
  localparam int K_DONE  = 2;
  localparam int K_BAD   = 3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [7:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              coeff_wr;
  logic [1:0]        coeff_addr;
  logic [7:0]        coeff_wdata;
  logic              load_req;
  logic signed [7:0] fir_x_n;
  logic              fir_tvalid;
  logic              fir_set_coeffs;
  logic              busy;
  logic              load_done;
  logic              wr_err;

  int  tests_run    = 0;
  int  tests_failed = 0;
  bit  mon_en       = 1'b0;
  ev_t sb_q[$];

  fir_load_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .coeff_wr       (coeff_wr),
    .coeff_addr     (coeff_addr),
    .coeff_wdata    (coeff_wdata),
    .load_req       (load_req),
    .fir_x_n        (fir_x_n),
    .fir_tvalid     (fir_tvalid),
    .fir_set_coeffs (fir_set_coeffs),
    .busy           (busy),
    .load_done      (load_done),
    .wr_err         (wr_err)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: every data/coefficient beat and every load_done pops one expected event
  always @(negedge clk) begin
    if (mon_en) begin
      if (fir_tvalid || fir_set_coeffs) begin
        logic [1:0] kind;
        ev_t        e;
        kind = (fir_set_coeffs && !fir_tvalid) ? 2'(K_COEFF) :
               (fir_tvalid && !fir_set_coeffs) ? 2'(K_DATA) : 2'(K_BAD);
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_beat got kind=%0d x=%0d, none expected", kind, fir_x_n);
        end else begin
          e = sb_q.pop_front();
          if (e.kind !== kind || e.val !== fir_x_n) begin
            tests_failed++;
            $display("FAIL sb_beat got kind=%0d x=%0d, expected kind=%0d x=%0d",
                     kind, fir_x_n, e.kind, e.val);
          end
        end
      end
      if (load_done) begin
        ev_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_done got load_done=1, none expected");
        end else begin
          e = sb_q.pop_front();
          if (e.kind !== 2'(K_DONE)) begin
            tests_failed++;
            $display("FAIL sb_done got load_done, expected kind=%0d x=%0d", e.kind, e.val);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = 2'(kind);
    e.val  = val;
    sb_q.push_back(e);
  endtask

  // Expected events of one full load sequence
  task automatic push_load(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    push(K_COEFF, c0);
    push(K_COEFF, c1);
    push(K_COEFF, c2);
`ifdef FIR_CTRL_FLUSH_EN
    for (int i = 0; i < 3; i++) push(K_DATA, 8'd0);
`endif
    push(K_DONE, 8'd0);
  endtask

  // Bounded wait for the scoreboard to empty, then idle cycles to catch stray events
  task automatic wait_sb(input string name);
    int budget = 40;
    while (sb_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    repeat (3) step();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain got %0d events outstanding, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d, input logic want_err, input string name);
    coeff_wr = 1'b1; coeff_addr = a; coeff_wdata = d;
    step();
    coeff_wr = 1'b0;
    tests_run++;
    if (wr_err !== want_err) begin
      tests_failed++;
      $display("FAIL %s_wr_err got %b, expected %b", name, wr_err, want_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_in = 8'sd5; sample_valid = 1'b1;
    coeff_wr = 1'b0; coeff_addr = 2'd0; coeff_wdata = 8'd0; load_req = 1'b0;
    step(); step();
    tests_run++;
    if (fir_x_n !== 8'sd0 || fir_tvalid !== 1'b0 || fir_set_coeffs !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fir got x=%0d tv=%b sc=%b, expected 0 0 0", fir_x_n, fir_tvalid, fir_set_coeffs);
    end
    tests_run++;
    if (busy !== 1'b0 || load_done !== 1'b0 || wr_err !== 1'b0 || sample_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_status got busy=%b done=%b err=%b rdy=%b, expected 0 0 0 1",
               busy, load_done, wr_err, sample_ready);
    end
    sample_valid = 1'b0; sample_in = 8'sd0;
    reset = 1'b0;
    step();
    mon_en = 1'b1;
  endtask

  task automatic test_passthrough();
    logic signed [7:0] vals [5];
    vals[0] = 8'sd0; vals[1] = 8'sd1; vals[2] = 8'sd0; vals[3] = -8'sd3; vals[4] = 8'sd127;
    for (int i = 0; i < 5; i++) begin
      sample_in = vals[i]; sample_valid = 1'b1;
      push(K_DATA, vals[i]);
      step();
      tests_run++;
      if (sample_ready !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL pass_ready got rdy=%b busy=%b, expected 1 0", sample_ready, busy);
      end
    end
    sample_valid = 1'b0;
    wait_sb("pass");
  endtask

  task automatic test_load();
    write(2'd0, 8'd1, 1'b0, "load_w0");
    write(2'd1, 8'd2, 1'b0, "load_w1");
    write(2'd2, 8'd3, 1'b0, "load_w2");
    sample_in = 8'sd7; sample_valid = 1'b1; load_req = 1'b1;
    push(K_DATA, 8'd7);
    push_load(8'd1, 8'd2, 8'd3);
    step();
    load_req = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || sample_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_busy got busy=%b rdy=%b, expected 1 0", busy, sample_ready);
    end
    sample_in = 8'sd9;
    step();
    sample_valid = 1'b0;
    wait_sb("load");
  endtask

  task automatic test_pending();
    load_req = 1'b1;
    push_load(8'd1, 8'd2, 8'd3);
    push_load(8'd1, 8'd2, 8'd3);
    step(); step(); step();
    load_req = 1'b0;
    wait_sb("pending");
  endtask

  task automatic test_same_cycle_write();
    coeff_wr = 1'b1; coeff_addr = 2'd1; coeff_wdata = 8'd5; load_req = 1'b1;
    push_load(8'd1, 8'd5, 8'd3);
    step();
    coeff_wr = 1'b0; load_req = 1'b0;
    tests_run++;
    if (wr_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_wr_err got %b, expected 0", wr_err);
    end
    wait_sb("same_cycle");
    write(2'd1, 8'd2, 1'b0, "restore");
  endtask

  task automatic test_busy_write();
    load_req = 1'b1;
    push_load(8'd1, 8'd2, 8'd3);
    step();
    load_req = 1'b0;
    write(2'd0, 8'd9, 1'b1, "busy");
    step();
    tests_run++;
    if (wr_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_err_pulse got %b, expected 0", wr_err);
    end
    wait_sb("busy1");
    write(2'd3, 8'd9, 1'b1, "addr3");
    step();
    tests_run++;
    if (wr_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL addr3_err_pulse got %b, expected 0", wr_err);
    end
    load_req = 1'b1;
    push_load(8'd1, 8'd2, 8'd3);
    step();
    load_req = 1'b0;
    wait_sb("busy2");
  endtask

  task automatic test_reset_mid_load();
    load_req = 1'b1;
    push(K_COEFF, 8'd1);
    push(K_COEFF, 8'd2);
    step();
    load_req = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (fir_set_coeffs !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid got sc=%b busy=%b done=%b, expected 0 0 0",
               fir_set_coeffs, busy, load_done);
    end
    wait_sb("reset_mid");
    load_req = 1'b1;
    push_load(8'd0, 8'd0, 8'd0);
    step();
    load_req = 1'b0;
    wait_sb("after_reset");
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load();
    test_pending();
    test_same_cycle_write();
    test_busy_write();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
